// File: rtl/axi_req_executor.sv
// Request executor: buffers 72-bit read/write requests in a small FIFO and
// replays them one at a time as AXI4-Lite master transactions.
module axi_req_executor #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [71:0] AXIS_REQ_TDATA,
    input  logic        AXIS_REQ_TVALID,
    output logic        AXIS_REQ_TREADY,
    output logic [31:0] M_AXI_AWADDR,
    output logic [2:0]  M_AXI_AWPROT,
    output logic        M_AXI_AWVALID,
    input  logic        M_AXI_AWREADY,
    output logic [31:0] M_AXI_WDATA,
    output logic [3:0]  M_AXI_WSTRB,
    output logic        M_AXI_WVALID,
    input  logic        M_AXI_WREADY,
    input  logic [1:0]  M_AXI_BRESP,
    input  logic        M_AXI_BVALID,
    output logic        M_AXI_BREADY,
    output logic [31:0] M_AXI_ARADDR,
    output logic [2:0]  M_AXI_ARPROT,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,
    input  logic [31:0] M_AXI_RDATA,
    input  logic [1:0]  M_AXI_RRESP,
    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY,
    output logic        rd_valid,
    output logic [31:0] rd_addr,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic [31:0] resp_errors,
    output logic [31:0] dropped
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RRESP} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [CW-1:0] count_q, count_d;
    logic [64:0]   mem_q [FIFO_DEPTH];
    logic [64:0]   headEntry;
    logic [31:0]   addr_q, addr_d, data_q, data_d;
    logic          awValid_q, awValid_d, wValid_q, wValid_d, bReady_q, bReady_d;
    logic          arValid_q, arValid_d, rReady_q, rReady_d;
    logic          rdValid_q, rdValid_d, busy_q, busy_d;
    logic [31:0]   rdAddr_q, rdAddr_d, rdData_q, rdData_d;
    logic [31:0]   respErr_q, respErr_d, dropped_q, dropped_d;
    logic          push, pop, dropReq, errInc;
    logic          unusedTdata;

    assign unusedTdata     = ^AXIS_REQ_TDATA[71:65];
    assign AXIS_REQ_TREADY = (count_q != FULL_COUNT);
    assign headEntry       = mem_q[rdPtr_q];

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awValid_q;
    assign M_AXI_WDATA   = data_q;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_WVALID  = wValid_q;
    assign M_AXI_BREADY  = bReady_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arValid_q;
    assign M_AXI_RREADY  = rReady_q;
    assign rd_valid      = rdValid_q;
    assign rd_addr       = rdAddr_q;
    assign rd_data       = rdData_q;
    assign busy          = busy_q;
    assign resp_errors   = respErr_q;
    assign dropped       = dropped_q;

    // FIFO storage has no reset; only the pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wrPtr_q] <= AXIS_REQ_TDATA[64:0];
        end
    end

    // Next-state logic for the transaction FSM, the FIFO bookkeeping and the status counters.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        awValid_d = awValid_q;
        wValid_d  = wValid_q;
        bReady_d  = bReady_q;
        arValid_d = arValid_q;
        rReady_d  = rReady_q;
        rdValid_d = 1'b0;
        rdAddr_d  = rdAddr_q;
        rdData_d  = rdData_q;
        pop       = 1'b0;
        errInc    = 1'b0;
        push      = AXIS_REQ_TVALID && (count_q != FULL_COUNT);
        dropReq   = AXIS_REQ_TVALID && (count_q == FULL_COUNT);

        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop    = 1'b1;
                    addr_d = headEntry[31:0];
                    data_d = headEntry[63:32];
                    if (headEntry[64]) begin
                        awValid_d = 1'b1;
                        wValid_d  = 1'b1;
                        state_d   = WRITE;
                    end else begin
                        arValid_d = 1'b1;
                        state_d   = READ;
                    end
                end
            end
            WRITE: begin
                if (awValid_q && M_AXI_AWREADY) begin
                    awValid_d = 1'b0;
                end
                if (wValid_q && M_AXI_WREADY) begin
                    wValid_d = 1'b0;
                end
                if ((!awValid_q || M_AXI_AWREADY) && (!wValid_q || M_AXI_WREADY)) begin
                    bReady_d = 1'b1;
                    state_d  = WRESP;
                end
            end
            WRESP: begin
                if (M_AXI_BVALID) begin
                    bReady_d = 1'b0;
                    errInc   = (M_AXI_BRESP != 2'b00);
                    state_d  = IDLE;
                end
            end
            READ: begin
                if (M_AXI_ARREADY) begin
                    arValid_d = 1'b0;
                    rReady_d  = 1'b1;
                    state_d   = RRESP;
                end
            end
            RRESP: begin
                if (M_AXI_RVALID) begin
                    rReady_d  = 1'b0;
                    rdValid_d = 1'b1;
                    rdData_d  = M_AXI_RDATA;
                    rdAddr_d  = addr_q;
                    errInc    = (M_AXI_RRESP != 2'b00);
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        wrPtr_d = push ? wrPtr_q + 1'b1 : wrPtr_q;
        rdPtr_d = pop ? rdPtr_q + 1'b1 : rdPtr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        respErr_d = (errInc && (respErr_q != '1)) ? respErr_q + 32'd1 : respErr_q;
        dropped_d = (dropReq && (dropped_q != '1)) ? dropped_q + 32'd1 : dropped_q;
        busy_d    = (state_d != IDLE) || (count_d != '0);
    end

    // State register; reset abandons any transaction in flight and empties the FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            awValid_q <= 1'b0;
            wValid_q  <= 1'b0;
            bReady_q  <= 1'b0;
            arValid_q <= 1'b0;
            rReady_q  <= 1'b0;
            rdValid_q <= 1'b0;
            rdAddr_q  <= '0;
            rdData_q  <= '0;
            busy_q    <= 1'b0;
            respErr_q <= '0;
            dropped_q <= '0;
        end else begin
            state_q   <= state_d;
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            count_q   <= count_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            awValid_q <= awValid_d;
            wValid_q  <= wValid_d;
            bReady_q  <= bReady_d;
            arValid_q <= arValid_d;
            rReady_q  <= rReady_d;
            rdValid_q <= rdValid_d;
            rdAddr_q  <= rdAddr_d;
            rdData_q  <= rdData_d;
            busy_q    <= busy_d;
            respErr_q <= respErr_d;
            dropped_q <= dropped_d;
        end
    end

endmodule

// File: tb/tb_axi_req_executor.sv
// Bench for axi_req_executor: an AXI4-Lite slave model answers each request
// from the front of a scoreboard queue filled as requests are driven.
module tb_axi_req_executor;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [71:0] AXIS_REQ_TDATA = '0;
    logic        AXIS_REQ_TVALID = 1'b0;
    logic        AXIS_REQ_TREADY;
    logic [31:0] M_AXI_AWADDR;
    logic [2:0]  M_AXI_AWPROT;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY = 1'b0;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WVALID;
    logic        M_AXI_WREADY = 1'b0;
    logic [1:0]  M_AXI_BRESP = 2'b00;
    logic        M_AXI_BVALID = 1'b0;
    logic        M_AXI_BREADY;
    logic [31:0] M_AXI_ARADDR;
    logic [2:0]  M_AXI_ARPROT;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY = 1'b0;
    logic [31:0] M_AXI_RDATA = '0;
    logic [1:0]  M_AXI_RRESP = 2'b00;
    logic        M_AXI_RVALID = 1'b0;
    logic        M_AXI_RREADY;
    logic        rd_valid;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic        busy;
    logic [31:0] resp_errors;
    logic [31:0] dropped;

    typedef struct {
        logic        mode;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } txn_t;

    typedef struct {
        logic        mode;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [31:0] expErrors;
    } vec_t;

    txn_t sbQ[$];
    vec_t vecs[6];

    int checks = 0;
    int errors = 0;
    int bCount = 0;
    int rCount = 0;
    int rdPulseCount = 0;
    int hsCount = 0;
    int awDelay = 0;
    int wDelay = 0;
    bit awStall = 1'b0;
    bit arStall = 1'b0;

    int   awCnt = 0;
    int   wCnt = 0;
    bit   awGot = 1'b0;
    bit   wGot = 1'b0;
    bit   bPend = 1'b0;
    bit   rPend = 1'b0;
    bit   bDrop = 1'b0;
    bit   rDrop = 1'b0;
    txn_t cur;
    txn_t popped;

    axi_req_executor #(.FIFO_DEPTH(16)) dut (
        .clk(clk),
        .reset(reset),
        .AXIS_REQ_TDATA(AXIS_REQ_TDATA),
        .AXIS_REQ_TVALID(AXIS_REQ_TVALID),
        .AXIS_REQ_TREADY(AXIS_REQ_TREADY),
        .M_AXI_AWADDR(M_AXI_AWADDR),
        .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID),
        .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA),
        .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID),
        .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP),
        .M_AXI_BVALID(M_AXI_BVALID),
        .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR),
        .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID),
        .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA),
        .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID),
        .M_AXI_RREADY(M_AXI_RREADY),
        .rd_valid(rd_valid),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .busy(busy),
        .resp_errors(resp_errors),
        .dropped(dropped)
    );

    // 100 MHz free-running clock.
    always #5 clk = ~clk;

    // Hard time limit so a stuck handshake can never hang the run.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic popFront(input string name, output txn_t t);
        checks++;
        if (sbQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s: got a completion, expected an empty scoreboard", name);
            t = '{1'b0, 32'h0, 32'h0, 2'b00, 32'h0};
        end else begin
            t = sbQ.pop_front();
        end
    endtask

    // Slave model and output monitor. Readies/valids are decided at the falling
    // edge for the rising edge that follows, so a handshake seen here is the one
    // the DUT will take on the next rising edge.
    always @(negedge clk) begin
        if (reset) begin
            M_AXI_AWREADY = 1'b0;
            M_AXI_WREADY  = 1'b0;
            M_AXI_BVALID  = 1'b0;
            M_AXI_BRESP   = 2'b00;
            M_AXI_ARREADY = 1'b0;
            M_AXI_RVALID  = 1'b0;
            M_AXI_RDATA   = '0;
            M_AXI_RRESP   = 2'b00;
            awCnt = 0;
            wCnt  = 0;
            awGot = 1'b0;
            wGot  = 1'b0;
            bPend = 1'b0;
            rPend = 1'b0;
            bDrop = 1'b0;
            rDrop = 1'b0;
        end else begin
            if (rd_valid) begin
                rdPulseCount++;
                popFront("rd_valid completion", popped);
                checkOutput("rd_addr vs scoreboard", rd_addr, popped.addr);
                checkOutput("rd_data vs scoreboard", rd_data, popped.rdata);
            end

            if (bDrop) begin
                M_AXI_BVALID = 1'b0;
                bDrop = 1'b0;
            end
            if (bPend) begin
                M_AXI_BVALID = 1'b1;
                M_AXI_BRESP  = cur.resp;
                bPend = 1'b0;
            end
            if (M_AXI_BVALID && M_AXI_BREADY) begin
                bCount++;
                hsCount++;
                bDrop = 1'b1;
                popFront("B completion", popped);
            end

            if (rDrop) begin
                M_AXI_RVALID = 1'b0;
                rDrop = 1'b0;
            end
            if (rPend) begin
                M_AXI_RVALID = 1'b1;
                M_AXI_RDATA  = cur.rdata;
                M_AXI_RRESP  = cur.resp;
                rPend = 1'b0;
            end
            if (M_AXI_RVALID && M_AXI_RREADY) begin
                rCount++;
                hsCount++;
                rDrop = 1'b1;
            end

            if (M_AXI_AWVALID && !awGot) begin
                if (!awStall && awCnt >= awDelay) begin
                    M_AXI_AWREADY = 1'b1;
                end else begin
                    M_AXI_AWREADY = 1'b0;
                    if (!awStall) awCnt++;
                end
            end else begin
                M_AXI_AWREADY = 1'b0;
                awCnt = 0;
            end
            if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                hsCount++;
                awGot = 1'b1;
                awCnt = 0;
                checks++;
                if (sbQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL AW handshake: got addr 0x%08h, expected no transaction", M_AXI_AWADDR);
                end else begin
                    cur = sbQ[0];
                    checkOutput("AW mode", {31'b0, cur.mode}, 32'd1);
                    checkOutput("AWADDR", M_AXI_AWADDR, cur.addr);
                end
            end

            if (M_AXI_WVALID && !wGot) begin
                if (wCnt >= wDelay) begin
                    M_AXI_WREADY = 1'b1;
                end else begin
                    M_AXI_WREADY = 1'b0;
                    wCnt++;
                end
            end else begin
                M_AXI_WREADY = 1'b0;
                wCnt = 0;
            end
            if (M_AXI_WVALID && M_AXI_WREADY) begin
                hsCount++;
                wGot = 1'b1;
                wCnt = 0;
                checks++;
                if (sbQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL W handshake: got data 0x%08h, expected no transaction", M_AXI_WDATA);
                end else begin
                    cur = sbQ[0];
                    checkOutput("WDATA", M_AXI_WDATA, cur.data);
                    checkOutput("WSTRB", {28'b0, M_AXI_WSTRB}, 32'hF);
                end
            end
            if (awGot && wGot) begin
                bPend = 1'b1;
                awGot = 1'b0;
                wGot  = 1'b0;
            end

            M_AXI_ARREADY = M_AXI_ARVALID && !arStall;
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                hsCount++;
                rPend = 1'b1;
                checks++;
                if (sbQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL AR handshake: got addr 0x%08h, expected no transaction", M_AXI_ARADDR);
                end else begin
                    cur = sbQ[0];
                    checkOutput("AR mode", {31'b0, cur.mode}, 32'd0);
                    checkOutput("ARADDR", M_AXI_ARADDR, cur.addr);
                end
            end
        end
    end

    // Drive one request strobe and queue what the slave should see for it.
    task automatic applyStimulus(input logic mode, input logic [31:0] addr, input logic [31:0] data,
                                 input logic [1:0] resp, input logic [31:0] rdata, input bit expectAccept);
        txn_t t;
        @(negedge clk);
        AXIS_REQ_TDATA  = {7'h00, mode, data, addr};
        AXIS_REQ_TVALID = 1'b1;
        checkOutput("TREADY at strobe", {31'b0, AXIS_REQ_TREADY}, {31'b0, expectAccept});
        if (expectAccept) begin
            t = '{mode, addr, data, resp, rdata};
            sbQ.push_back(t);
        end
    endtask

    task automatic endStimulus();
        @(negedge clk);
        AXIS_REQ_TVALID = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (!busy && sbQ.size() == 0) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL waitIdle: busy=%0b pending=%0d after %0d cycles, expected idle", busy, sbQ.size(), budget);
        end
        @(negedge clk);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " AWVALID"}, {31'b0, M_AXI_AWVALID}, 32'd0);
        checkOutput({tag, " WVALID"}, {31'b0, M_AXI_WVALID}, 32'd0);
        checkOutput({tag, " BREADY"}, {31'b0, M_AXI_BREADY}, 32'd0);
        checkOutput({tag, " ARVALID"}, {31'b0, M_AXI_ARVALID}, 32'd0);
        checkOutput({tag, " RREADY"}, {31'b0, M_AXI_RREADY}, 32'd0);
        checkOutput({tag, " AWADDR"}, M_AXI_AWADDR, 32'd0);
        checkOutput({tag, " WDATA"}, M_AXI_WDATA, 32'd0);
        checkOutput({tag, " ARADDR"}, M_AXI_ARADDR, 32'd0);
        checkOutput({tag, " WSTRB"}, {28'b0, M_AXI_WSTRB}, 32'hF);
        checkOutput({tag, " PROT"}, {26'b0, M_AXI_AWPROT, M_AXI_ARPROT}, 32'd0);
        checkOutput({tag, " rd_valid"}, {31'b0, rd_valid}, 32'd0);
        checkOutput({tag, " rd_addr"}, rd_addr, 32'd0);
        checkOutput({tag, " rd_data"}, rd_data, 32'd0);
        checkOutput({tag, " busy"}, {31'b0, busy}, 32'd0);
        checkOutput({tag, " resp_errors"}, resp_errors, 32'd0);
        checkOutput({tag, " dropped"}, dropped, 32'd0);
    endtask

    // Main sequence: reset, timed single transactions, vector table, corner cases.
    initial begin
        int bBase;
        int hsBase;
        int pulseBase;

        vecs[0] = '{1'b1, 32'h0000_1100, 32'h0F0F_0F0F, 2'd0, 32'h0, 32'd0};
        vecs[1] = '{1'b0, 32'h0000_2200, 32'h0,         2'd0, 32'h8765_4321, 32'd0};
        vecs[2] = '{1'b1, 32'h0000_3000, 32'hCAFE_F00D, 2'd2, 32'h0, 32'd1};
        vecs[3] = '{1'b0, 32'h0000_4008, 32'h0,         2'd3, 32'hA5A5_A5A5, 32'd2};
        vecs[4] = '{1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 2'd0, 32'h0, 32'd2};
        vecs[5] = '{1'b0, 32'h0000_0000, 32'h0,         2'd1, 32'hFFFF_FFFF, 32'd3};

        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        checkOutput("reset TREADY", {31'b0, AXIS_REQ_TREADY}, 32'd1);
        #2 reset = 1'b0;

        $display("[TB] single write");
        bBase = bCount;
        applyStimulus(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 2'd0, 32'h0, 1'b1);
        endStimulus();
        checkOutput("write N+1 AWVALID", {31'b0, M_AXI_AWVALID}, 32'd0);
        checkOutput("write N+1 busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        checkOutput("write N+2 AWVALID", {31'b0, M_AXI_AWVALID}, 32'd1);
        checkOutput("write N+2 WVALID", {31'b0, M_AXI_WVALID}, 32'd1);
        checkOutput("write N+2 AWADDR", M_AXI_AWADDR, 32'h0000_1000);
        checkOutput("write N+2 WDATA", M_AXI_WDATA, 32'hDEAD_BEEF);
        @(negedge clk);
        checkOutput("write N+3 AWVALID", {31'b0, M_AXI_AWVALID}, 32'd0);
        checkOutput("write N+3 BREADY", {31'b0, M_AXI_BREADY}, 32'd1);
        @(negedge clk);
        checkOutput("write N+4 BREADY", {31'b0, M_AXI_BREADY}, 32'd0);
        checkOutput("write N+4 busy", {31'b0, busy}, 32'd0);
        waitIdle(50);
        checkOutput("write B count", bCount - bBase, 32'd1);
        checkOutput("write resp_errors", resp_errors, 32'd0);

        $display("[TB] single read");
        applyStimulus(1'b0, 32'h0000_2004, 32'h0, 2'd0, 32'h1234_5678, 1'b1);
        endStimulus();
        @(negedge clk);
        checkOutput("read N+2 ARVALID", {31'b0, M_AXI_ARVALID}, 32'd1);
        checkOutput("read N+2 ARADDR", M_AXI_ARADDR, 32'h0000_2004);
        @(negedge clk);
        checkOutput("read N+3 ARVALID", {31'b0, M_AXI_ARVALID}, 32'd0);
        checkOutput("read N+3 RREADY", {31'b0, M_AXI_RREADY}, 32'd1);
        @(negedge clk);
        checkOutput("read N+4 rd_valid", {31'b0, rd_valid}, 32'd1);
        checkOutput("read N+4 rd_addr", rd_addr, 32'h0000_2004);
        checkOutput("read N+4 rd_data", rd_data, 32'h1234_5678);
        checkOutput("read N+4 RREADY", {31'b0, M_AXI_RREADY}, 32'd0);
        @(negedge clk);
        checkOutput("read N+5 rd_valid", {31'b0, rd_valid}, 32'd0);
        waitIdle(50);

        $display("[TB] vector table");
        pulseBase = rdPulseCount;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].mode, vecs[i].addr, vecs[i].data, vecs[i].resp, vecs[i].rdata, 1'b1);
            endStimulus();
            waitIdle(50);
            checkOutput($sformatf("vec%0d resp_errors", i), resp_errors, vecs[i].expErrors);
        end
        checkOutput("vector rd_valid pulses", rdPulseCount - pulseBase, 32'd3);

        $display("[TB] split handshakes");
        awDelay = 3;
        wDelay  = 0;
        bBase = bCount;
        applyStimulus(1'b1, 32'h0000_7000, 32'h1111_2222, 2'd0, 32'h0, 1'b1);
        endStimulus();
        @(negedge clk);
        @(negedge clk);
        checkOutput("aw-late AWVALID", {31'b0, M_AXI_AWVALID}, 32'd1);
        checkOutput("aw-late WVALID", {31'b0, M_AXI_WVALID}, 32'd0);
        checkOutput("aw-late BREADY", {31'b0, M_AXI_BREADY}, 32'd0);
        waitIdle(50);
        awDelay = 0;
        wDelay  = 3;
        applyStimulus(1'b1, 32'h0000_7004, 32'h3333_4444, 2'd0, 32'h0, 1'b1);
        endStimulus();
        @(negedge clk);
        @(negedge clk);
        checkOutput("w-late AWVALID", {31'b0, M_AXI_AWVALID}, 32'd0);
        checkOutput("w-late WVALID", {31'b0, M_AXI_WVALID}, 32'd1);
        checkOutput("w-late BREADY", {31'b0, M_AXI_BREADY}, 32'd0);
        waitIdle(50);
        wDelay = 0;
        checkOutput("split B count", bCount - bBase, 32'd2);

        $display("[TB] overflow");
        bBase = bCount;
        awStall = 1'b1;
        applyStimulus(1'b1, 32'h0000_5000, 32'h0000_0050, 2'd0, 32'h0, 1'b1);
        endStimulus();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 32'h0000_6000 + 32'(4 * i), 32'(i), 2'd0, 32'h0, i < 16);
        end
        endStimulus();
        checkOutput("overflow dropped", dropped, 32'd4);
        checkOutput("overflow TREADY", {31'b0, AXIS_REQ_TREADY}, 32'd0);
        checkOutput("overflow busy", {31'b0, busy}, 32'd1);
        awStall = 1'b0;
        waitIdle(500);
        checkOutput("overflow B count", bCount - bBase, 32'd17);
        checkOutput("overflow busy after", {31'b0, busy}, 32'd0);
        checkOutput("overflow TREADY after", {31'b0, AXIS_REQ_TREADY}, 32'd1);

        $display("[TB] reset mid-read");
        arStall = 1'b1;
        pulseBase = rdPulseCount;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 32'h0000_8000 + 32'(4 * i), 32'h0, 2'd0, 32'hBAD0_0000 + 32'(i), 1'b1);
        end
        endStimulus();
        checkOutput("mid-read ARVALID", {31'b0, M_AXI_ARVALID}, 32'd1);
        #2 reset = 1'b1;
        #1;
        checkResetOutputs("mid-reset");
        sbQ.delete();
        arStall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        hsBase = hsCount;
        repeat (10) @(negedge clk);
        checkOutput("post-reset busy", {31'b0, busy}, 32'd0);
        checkOutput("post-reset ARVALID", {31'b0, M_AXI_ARVALID}, 32'd0);
        checkOutput("post-reset AWVALID", {31'b0, M_AXI_AWVALID}, 32'd0);
        checkOutput("post-reset handshakes", hsCount - hsBase, 32'd0);
        checkOutput("post-reset rd_valid pulses", rdPulseCount - pulseBase, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
